// File: rtl/zl_conv_interleaver.sv
`default_nettype none
// ============================================================================
// Module   : zl_conv_interleaver
// Purpose  : Forney convolutional (de)interleaver with zero-masked arm priming.
//            Optional frame sync check enabled by ZL_CONV_INTERLEAVER_SYNC_EN.
// Revision : 1.0 - initial release
// ============================================================================
module zl_conv_interleaver #(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    N_BRANCHES   = 12,
  parameter int                    BRANCH_DELAY = 17,
  parameter int                    FRAME_LEN    = 204,
  parameter bit                    DEINTERLEAVE = 1'b0,
  parameter logic [DATA_WIDTH-1:0] SYNC_WORD    = DATA_WIDTH'(8'h47)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_req,
  output logic                  in_ack,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_req,
  input  logic                  out_ack,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  sync_locked
);

  localparam int c_bw = $clog2(N_BRANCHES);
  localparam int c_pw = $clog2((N_BRANCHES - 1) * BRANCH_DELAY + 1);
  localparam int c_aw = c_bw + c_pw;
  localparam int c_fw = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [c_bw-1:0] c_last_arm = c_bw'(N_BRANCHES - 1);
  localparam logic [c_fw-1:0] c_last_pos = c_fw'(FRAME_LEN - 1);
`ifdef ZL_CONV_INTERLEAVER_SYNC_EN
  localparam bit c_sync_en = 1'b1;
`else
  localparam bit c_sync_en = 1'b0;
`endif

  function automatic logic [c_pw-1:0] f_delay(input logic [c_bw-1:0] arm);
    int idx;
    idx = DEINTERLEAVE ? (N_BRANCHES - 1 - int'(arm)) : int'(arm);
    return c_pw'(idx * BRANCH_DELAY);
  endfunction

  logic [c_bw-1:0]       r_sel;
  logic [c_fw-1:0]       r_frame;
  logic [c_pw-1:0]       r_wr_ptr [N_BRANCHES];
  logic [c_pw-1:0]       r_prime  [N_BRANCHES];
  logic [2:0]            r_credits;
  logic [DATA_WIDTH-1:0] r_mem    [2**c_aw];
  logic [DATA_WIDTH-1:0] r_rd_q;
  logic                  r_s1_vld;
  logic                  r_s1_mask;
  logic                  r_s1_byp;
  logic [DATA_WIDTH-1:0] r_s1_data;
  logic                  r_s2_vld;
  logic [DATA_WIDTH-1:0] r_s2_data;
  logic [DATA_WIDTH-1:0] r_fifo   [4];
  logic [1:0]            r_wptr;
  logic [1:0]            r_rptr;
  logic [2:0]            r_count;

  logic                  w_acc;
  logic                  w_pos0;
  logic                  w_sync_ok;
  logic                  w_resync;
  logic                  w_byp;
  logic                  w_primed;
  logic                  w_pop;
  logic [c_bw-1:0]       w_arm;
  logic [c_pw-1:0]       w_delay;
  logic [c_pw-1:0]       w_wr_ptr;
  logic [c_pw-1:0]       w_rd_ptr;
  logic [c_aw-1:0]       w_wr_addr;
  logic [c_aw-1:0]       w_rd_addr;

  // Credits cover the read pipeline plus the FIFO, so the FIFO can never overflow.
  assign in_ack    = in_req && (r_credits < 3'd4) && rst_n;
  assign w_acc     = in_ack;
  assign w_pop     = out_ack && out_req;
  assign w_pos0    = (r_frame == '0);
  assign w_sync_ok = (in_data == SYNC_WORD) || (in_data == ~SYNC_WORD);
  assign w_resync  = c_sync_en && w_pos0 && !w_sync_ok;
  assign w_arm     = w_resync ? '0 : r_sel;
  assign w_delay   = f_delay(w_arm);
  assign w_wr_ptr  = r_wr_ptr[w_arm];
  assign w_rd_ptr  = w_wr_ptr - w_delay;
  assign w_byp     = (w_rd_ptr == w_wr_ptr);
  assign w_primed  = (r_prime[w_arm] >= w_delay);
  assign w_wr_addr = {w_arm, w_wr_ptr};
  assign w_rd_addr = {w_arm, w_rd_ptr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel   <= '0;
      r_frame <= '0;
      for (int i = 0; i < N_BRANCHES; i++) begin
        r_wr_ptr[i] <= '0;
        r_prime[i]  <= '0;
      end
    end else if (w_acc) begin
      r_wr_ptr[w_arm] <= w_wr_ptr + c_pw'(1);
      if (!w_primed) begin
        r_prime[w_arm] <= r_prime[w_arm] + c_pw'(1);
      end
      if (w_resync) begin
        r_sel   <= '0;
        r_frame <= '0;
      end else begin
        r_sel   <= (r_sel == c_last_arm) ? '0 : r_sel + c_bw'(1);
        r_frame <= (r_frame == c_last_pos) ? '0 : r_frame + c_fw'(1);
      end
    end
  end

  // Arm storage is never cleared; the prime counters hide stale contents.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_mem[w_wr_addr] <= in_data;
    end
    if (w_acc && !w_byp) begin
      r_rd_q <= r_mem[w_rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_mask <= 1'b0;
      r_s1_byp  <= 1'b0;
      r_s1_data <= '0;
      r_s2_vld  <= 1'b0;
      r_s2_data <= '0;
    end else begin
      r_s1_vld <= w_acc;
      if (w_acc) begin
        r_s1_mask <= !w_primed;
        r_s1_byp  <= w_byp;
        r_s1_data <= in_data;
      end
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_data <= r_s1_mask ? '0 : (r_s1_byp ? r_s1_data : r_rd_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_fifo[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (r_s2_vld) begin
        r_fifo[r_wptr] <= r_s2_data;
        r_wptr         <= r_wptr + 2'd1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 2'd1;
      end
      case ({r_s2_vld, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credits <= '0;
    end else begin
      case ({w_acc, w_pop})
        2'b10:   r_credits <= r_credits + 3'd1;
        2'b01:   r_credits <= r_credits - 3'd1;
        default: r_credits <= r_credits;
      endcase
    end
  end

  assign out_req  = (r_count != 3'd0);
  assign out_data = out_req ? r_fifo[r_rptr] : '0;

`ifdef ZL_CONV_INTERLEAVER_SYNC_EN
  logic r_locked;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_locked <= 1'b0;
    end else if (w_acc && w_pos0) begin
      r_locked <= w_sync_ok;
    end
  end

  assign sync_locked = r_locked;
`else
  assign sync_locked = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_zl_conv_interleaver.sv
`default_nettype none
// ============================================================================
// Module   : tb_zl_conv_interleaver
// Purpose  : Scoreboard bench: small interleaver, chained pair and default build.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_zl_conv_interleaver;

`ifdef ZL_CONV_INTERLEAVER_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int ack_mode = 0;
  logic a_ack_en = 1'b0;
  byte unsigned q_a[$];
  byte unsigned q_c[$];
  byte unsigned q_s[$];
  byte unsigned exp1 [15] = '{1, 0, 0, 4, 0, 0, 7, 2, 0, 10, 5, 0, 13, 8, 3};

  logic       a_in_req = 1'b0, a_in_ack, a_out_req, a_out_ack, a_lock;
  logic [7:0] a_in_data = '0, a_out_data;
  logic       c_in_req = 1'b0, c_in_ack, m_req, m_ack, i_lock, c_out_req, c_out_ack, d_lock;
  logic [7:0] c_in_data = '0, m_data, c_out_data;
  logic       s_in_req = 1'b0, s_in_ack, s_out_req, s_out_ack, s_lock;
  logic [7:0] s_in_data = '0, s_out_data;

  assign a_out_ack = a_out_req & a_ack_en;
  assign c_out_ack = c_out_req;
  assign s_out_ack = s_out_req;

  zl_conv_interleaver #(.DATA_WIDTH(8), .N_BRANCHES(3), .BRANCH_DELAY(2), .FRAME_LEN(204),
    .DEINTERLEAVE(1'b0), .SYNC_WORD(8'h01)) u_a (
    .clk(clk), .rst_n(rst_n), .in_req(a_in_req), .in_ack(a_in_ack), .in_data(a_in_data),
    .out_req(a_out_req), .out_ack(a_out_ack), .out_data(a_out_data), .sync_locked(a_lock));

  zl_conv_interleaver #(.DATA_WIDTH(8), .N_BRANCHES(3), .BRANCH_DELAY(2), .FRAME_LEN(204),
    .DEINTERLEAVE(1'b0), .SYNC_WORD(8'h01)) u_i (
    .clk(clk), .rst_n(rst_n), .in_req(c_in_req), .in_ack(c_in_ack), .in_data(c_in_data),
    .out_req(m_req), .out_ack(m_ack), .out_data(m_data), .sync_locked(i_lock));

  zl_conv_interleaver #(.DATA_WIDTH(8), .N_BRANCHES(3), .BRANCH_DELAY(2), .FRAME_LEN(204),
    .DEINTERLEAVE(1'b1), .SYNC_WORD(8'h01)) u_d (
    .clk(clk), .rst_n(rst_n), .in_req(m_req), .in_ack(m_ack), .in_data(m_data),
    .out_req(c_out_req), .out_ack(c_out_ack), .out_data(c_out_data), .sync_locked(d_lock));

  zl_conv_interleaver u_s (
    .clk(clk), .rst_n(rst_n), .in_req(s_in_req), .in_ack(s_in_ack), .in_data(s_in_data),
    .out_req(s_out_req), .out_ack(s_out_ack), .out_data(s_out_data), .sync_locked(s_lock));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  // Consumer side of u_a: acknowledge always, never, or at random.
  always @(posedge clk) begin
    #1;
    case (ack_mode)
      0:       a_ack_en = 1'b1;
      1:       a_ack_en = 1'b0;
      default: a_ack_en = ($urandom_range(1, 0) != 0);
    endcase
  end

  always @(negedge clk) begin : mon_a
    byte unsigned e;
    if (rst_n && a_out_req && a_out_ack) begin
      chk("a_unexpected_out", {31'd0, q_a.size() == 0}, 32'd0);
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        chk("a_out_data", {24'd0, a_out_data}, {24'd0, e});
      end
    end
  end

  always @(negedge clk) begin : mon_c
    byte unsigned e;
    if (rst_n && c_out_req && c_out_ack) begin
      chk("chain_unexpected_out", {31'd0, q_c.size() == 0}, 32'd0);
      if (q_c.size() > 0) begin
        e = q_c.pop_front();
        chk("chain_out_data", {24'd0, c_out_data}, {24'd0, e});
      end
    end
  end

  always @(negedge clk) begin : mon_s
    byte unsigned e;
    if (rst_n && s_out_req && s_out_ack) begin
      chk("s_unexpected_out", {31'd0, q_s.size() == 0}, 32'd0);
      if (q_s.size() > 0) begin
        e = q_s.pop_front();
        chk("s_out_data", {24'd0, s_out_data}, {24'd0, e});
      end
    end
  end

  function automatic int qsize(input int which);
    case (which)
      0:       return q_a.size();
      1:       return q_c.size();
      default: return q_s.size();
    endcase
  endfunction

  function automatic logic get_ack(input int which);
    case (which)
      0:       return a_in_ack;
      1:       return c_in_ack;
      default: return s_in_ack;
    endcase
  endfunction

  task automatic send(input int which, input logic [7:0] v, input logic [7:0] e);
    int   t = 0;
    logic ack;
    case (which)
      0:       begin a_in_req = 1'b1; a_in_data = v; end
      1:       begin c_in_req = 1'b1; c_in_data = v; end
      default: begin s_in_req = 1'b1; s_in_data = v; end
    endcase
    @(negedge clk);
    ack = get_ack(which);
    while (!ack && t < 200) begin
      t++;
      @(negedge clk);
      ack = get_ack(which);
    end
    chk("accept_timeout", {31'd0, ack}, 32'd1);
    if (ack) begin
      case (which)
        0:       q_a.push_back(e);
        1:       q_c.push_back(e);
        default: q_s.push_back(e);
      endcase
    end
    @(posedge clk);
    #1;
    a_in_req = 1'b0;
    c_in_req = 1'b0;
    s_in_req = 1'b0;
  endtask

  task automatic drain(input int which);
    int t = 0;
    while (qsize(which) != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_pending", qsize(which), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    q_a.delete();
    q_c.delete();
    q_s.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int idx;
    // Reset state, with a request pending
    a_in_req  = 1'b1;
    a_in_data = 8'h01;
    repeat (2) @(negedge clk);
    chk("rst_in_ack", {31'd0, a_in_ack}, 32'd0);
    chk("rst_out_req", {31'd0, a_out_req}, 32'd0);
    chk("rst_out_data", {24'd0, a_out_data}, 32'd0);
    chk("rst_lock", {31'd0, a_lock}, {31'd0, !SYNC});
    a_in_req = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Interleaver N=3, M=2, always acknowledged
    ack_mode = 0;
    for (int i = 0; i < 15; i++) send(0, 8'(i + 1), exp1[i]);
    drain(0);
    chk("a_lock_after_run", {31'd0, a_lock}, 32'd1);

    // Interleaver chained into deinterleaver: 12-symbol end-to-end delay
    do_reset();
    for (int k = 1; k <= 40; k++) send(1, 8'(k), (k <= 12) ? 8'd0 : 8'(k - 12));
    drain(1);
    chk("chain_i_lock", {31'd0, i_lock}, 32'd1);
    chk("chain_d_lock", {31'd0, d_lock}, 32'd1);

    // Backpressure: only four symbols may be in flight
    do_reset();
    ack_mode = 1;
    idx = 0;
    a_in_req = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      a_in_data = 8'(idx + 1);
      @(negedge clk);
      if (a_in_ack) begin
        q_a.push_back(exp1[idx]);
        idx++;
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("bp_accepts", idx, 32'd4);
    chk("bp_in_ack_low", {31'd0, a_in_ack}, 32'd0);
    chk("bp_out_req", {31'd0, a_out_req}, 32'd1);
    a_in_req = 1'b0;
    ack_mode = 2;
    for (int i = 4; i < 15; i++) send(0, 8'(i + 1), exp1[i]);
    drain(0);

    // Reset with three symbols parked in the FIFO
    do_reset();
    ack_mode = 1;
    for (int i = 0; i < 3; i++) send(0, 8'(i + 1), exp1[i]);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_out_req", {31'd0, a_out_req}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    q_a.delete();
    @(negedge clk);
    chk("mid_rst_out_req", {31'd0, a_out_req}, 32'd0);
    chk("mid_rst_out_data", {24'd0, a_out_data}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ack_mode = 0;
    for (int i = 0; i < 15; i++) send(0, 8'(i + 1), exp1[i]);
    drain(0);

    // Default build: frame-start alignment on arm 0
    do_reset();
    send(2, 8'h11, 8'h11);
    chk("s_lock_bad1", {31'd0, s_lock}, {31'd0, !SYNC});
    send(2, 8'h22, SYNC ? 8'h22 : 8'h00);
    chk("s_lock_bad2", {31'd0, s_lock}, {31'd0, !SYNC});
    send(2, 8'h47, SYNC ? 8'h47 : 8'h00);
    chk("s_lock_sync", {31'd0, s_lock}, 32'd1);
    send(2, 8'h55, 8'h00);
    drain(2);

    // Inverted sync word locks; a bad byte at the next frame start unlocks
    do_reset();
    send(2, 8'hB8, 8'hB8);
    chk("s_lock_inv", {31'd0, s_lock}, 32'd1);
    for (int i = 1; i < 204; i++) send(2, 8'h00, 8'h00);
    chk("s_lock_frame_end", {31'd0, s_lock}, 32'd1);
    send(2, 8'h00, 8'h00);
    chk("s_lock_next_frame", {31'd0, s_lock}, {31'd0, !SYNC});
    drain(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
